// File: rtl/uart_rx_fifo_if.sv
// Receive-buffer bus: RX-side byte/error inputs, host read port and status.
// Pure wiring, no latency of its own.
// No backpressure on the RX side; the host paces reads with rd_en.
interface uart_rx_fifo_if #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) ();
    localparam int OCC_W = $clog2(DEPTH) + 1;

    // RX deserializer side
    logic [DATA_WIDTH-1:0] parallel_data;
    logic                  data_valid;
    logic                  parity_error;
    logic                  stop_error;

    // Host side
    logic                  rd_en;
    logic                  clr_status;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  empty;
    logic                  full;
    logic [OCC_W-1:0]      count;
    logic                  overflow;
    logic [CNT_WIDTH-1:0]  parity_err_count;
    logic [CNT_WIDTH-1:0]  stop_err_count;

    // Environment (RX FSM plus host) drives the requests
    modport master (
        output parallel_data, data_valid, parity_error, stop_error, rd_en, clr_status,
        input  rd_data, rd_valid, empty, full, count, overflow,
               parity_err_count, stop_err_count
    );

    // The buffer itself
    modport slave (
        input  parallel_data, data_valid, parity_error, stop_error, rd_en, clr_status,
        output rd_data, rd_valid, empty, full, count, overflow,
               parity_err_count, stop_err_count
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART RX byte FIFO with sticky overflow and saturating parity/stop error counters.
// Push visible after the write edge; rd_data/rd_valid registered, valid after the rd_en edge.
// No backpressure to RX: a byte arriving while full (and no pop) is dropped and flagged.
module uart_rx_fifo #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic           clk_based_on_prescale,
    input  logic           asy_reset,
    uart_rx_fifo_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0]     OCC_FULL = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0]     OCC_ONE  = OCC_W'(1);
    localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  overflow_q, overflow_d;
    logic [CNT_WIDTH-1:0]  par_cnt_q, par_cnt_d;
    logic [CNT_WIDTH-1:0]  stop_cnt_q, stop_cnt_d;
    logic                  par_dly_q, par_dly_d;
    logic                  stop_dly_q, stop_dly_d;

    logic pop_ok;
    logic push_ok;
    logic drop;
    logic par_rise;
    logic stop_rise;

    // Next-state logic: pointer/occupancy update, read register, status counters
    always_comb begin
        // A pop needs stored data; a push needs a free slot, which a same-cycle pop provides.
        // When empty, the pop is refused, so a simultaneous push never falls through.
        pop_ok  = bus.rd_en && (count_q != '0);
        push_ok = bus.data_valid && ((count_q != OCC_FULL) || pop_ok);
        drop    = bus.data_valid && !push_ok;

        mem_d = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = bus.parallel_data;
        end

        wr_ptr_d = push_ok ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + OCC_ONE;
            2'b01:   count_d = count_q - OCC_ONE;
            default: count_d = count_q;
        endcase

        // rd_data holds the last popped byte between pops
        rd_data_d  = pop_ok ? mem_q[rd_ptr_q] : rd_data_q;
        rd_valid_d = pop_ok;

        // Error inputs are levels; count only their rising edges
        par_rise   = bus.parity_error && !par_dly_q;
        stop_rise  = bus.stop_error   && !stop_dly_q;
        par_dly_d  = bus.parity_error;
        stop_dly_d = bus.stop_error;

        // Clear wins over any event landing in the same cycle
        if (bus.clr_status) begin
            overflow_d = 1'b0;
            par_cnt_d  = '0;
            stop_cnt_d = '0;
        end else begin
            overflow_d = overflow_q || drop;
            par_cnt_d  = (par_rise  && (par_cnt_q  != CNT_MAX)) ? (par_cnt_q  + CNT_ONE) : par_cnt_q;
            stop_cnt_d = (stop_rise && (stop_cnt_q != CNT_MAX)) ? (stop_cnt_q + CNT_ONE) : stop_cnt_q;
        end
    end

    // Storage array is not reset; stale contents are unreachable once count is cleared
    always_ff @(posedge clk_based_on_prescale) begin
        mem_q <= mem_d;
    end

    // Control and status registers with synchronous reset taking priority
    always_ff @(posedge clk_based_on_prescale) begin
        if (asy_reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
            par_cnt_q  <= '0;
            stop_cnt_q <= '0;
            par_dly_q  <= 1'b0;
            stop_dly_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            overflow_q <= overflow_d;
            par_cnt_q  <= par_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            par_dly_q  <= par_dly_d;
            stop_dly_q <= stop_dly_d;
        end
    end

    assign bus.rd_data          = rd_data_q;
    assign bus.rd_valid         = rd_valid_q;
    assign bus.count            = count_q;
    assign bus.empty            = (count_q == '0);
    assign bus.full             = (count_q == OCC_FULL);
    assign bus.overflow         = overflow_q;
    assign bus.parity_err_count = par_cnt_q;
    assign bus.stop_err_count   = stop_cnt_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus a randomized run.
// Outputs sampled 1 time unit after the rising edge; inputs change at the same point.
// Reference is a byte queue with plain counters, updated once per clock.
module tb_uart_rx_fifo;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DEPTH(DEPTH), .DATA_WIDTH(8), .CNT_WIDTH(8)) bus ();

    uart_rx_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
        .clk_based_on_prescale(clk),
        .asy_reset(rst),
        .bus(bus)
    );

    // Reference state
    logic [7:0] m_q[$];
    logic [7:0] m_rd_data = 8'h00;
    logic       m_rd_valid = 1'b0;
    logic       m_ovf = 1'b0;
    int         m_par = 0;
    int         m_stop = 0;
    logic       m_prev_par = 1'b0;
    logic       m_prev_stop = 1'b0;

    function automatic void model_step(input logic dv, input logic [7:0] d, input logic pe,
                                       input logic se, input logic re, input logic clr,
                                       input logic rs);
        logic dropped;
        if (rs) begin
            m_q.delete();
            m_rd_data = 8'h00; m_rd_valid = 1'b0; m_ovf = 1'b0;
            m_par = 0; m_stop = 0; m_prev_par = 1'b0; m_prev_stop = 1'b0;
            return;
        end
        m_rd_valid = 1'b0;
        if (re && m_q.size() > 0) begin
            m_rd_data  = m_q.pop_front();
            m_rd_valid = 1'b1;
        end
        dropped = 1'b0;
        if (dv) begin
            if (m_q.size() < DEPTH) m_q.push_back(d);
            else dropped = 1'b1;
        end
        if (clr) begin
            m_ovf = 1'b0; m_par = 0; m_stop = 0;
        end else begin
            m_ovf = m_ovf | dropped;
            if (pe && !m_prev_par && m_par < 255) m_par++;
            if (se && !m_prev_stop && m_stop < 255) m_stop++;
        end
        m_prev_par  = pe;
        m_prev_stop = se;
    endfunction

    // Apply one cycle of inputs, then sample just after the edge
    task automatic cyc(input logic dv, input logic [7:0] d, input logic pe, input logic se,
                       input logic re, input logic clr, input logic rs);
        bus.data_valid = dv; bus.parallel_data = d; bus.parity_error = pe;
        bus.stop_error = se; bus.rd_en = re; bus.clr_status = clr; rst = rs;
        @(posedge clk);
        #1;
        model_step(dv, d, pe, se, re, clr, rs);
    endtask

    task automatic idle();
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push(input logic [7:0] d);
        cyc(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop();
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_vec++; if (bus.count !== 4'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", bus.count); end
        n_vec++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin n_bad++; $display("FAIL reset_flags empty=%b full=%b want 1/0", bus.empty, bus.full); end
        n_vec++; if (bus.rd_data !== 8'h00 || bus.rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd got %h/%b want 00/0", bus.rd_data, bus.rd_valid); end
        n_vec++; if (bus.overflow !== 1'b0 || bus.parity_err_count !== 8'd0 || bus.stop_err_count !== 8'd0) begin n_bad++; $display("FAIL reset_status ovf=%b par=%0d stop=%0d want 0", bus.overflow, bus.parity_err_count, bus.stop_err_count); end
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_basic();
        logic [7:0] exp [3];
        exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            push(exp[i]);
            n_vec++; if (bus.count !== 4'(i + 1)) begin n_bad++; $display("FAIL basic_fill_count got %0d want %0d", bus.count, i + 1); end
        end
        for (int i = 0; i < 3; i++) begin
            pop();
            n_vec++; if (bus.rd_data !== exp[i] || bus.rd_valid !== 1'b1) begin n_bad++; $display("FAIL basic_pop%0d got %h/%b want %h/1", i, bus.rd_data, bus.rd_valid, exp[i]); end
            n_vec++; if (bus.count !== 4'(2 - i)) begin n_bad++; $display("FAIL basic_drain_count got %0d want %0d", bus.count, 2 - i); end
        end
        n_vec++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL basic_empty got %b want 1", bus.empty); end
        idle();
        n_vec++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 8'h33) begin n_bad++; $display("FAIL basic_hold got %h/%b want 33/0", bus.rd_data, bus.rd_valid); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i));
        n_vec++; if (bus.full !== 1'b1 || bus.count !== 4'd8) begin n_bad++; $display("FAIL ovf_full full=%b count=%0d want 1/8", bus.full, bus.count); end
        n_vec++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_early got %b want 0", bus.overflow); end
        push(8'hFF);
        n_vec++; if (bus.overflow !== 1'b1 || bus.count !== 4'd8) begin n_bad++; $display("FAIL ovf_drop ovf=%b count=%0d want 1/8", bus.overflow, bus.count); end
        for (int i = 0; i < 8; i++) begin
            pop();
            n_vec++; if (bus.rd_data !== 8'hA0 + 8'(i)) begin n_bad++; $display("FAIL ovf_drain%0d got %h want %h", i, bus.rd_data, 8'hA0 + 8'(i)); end
        end
        n_vec++; if (bus.empty !== 1'b1 || bus.overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_after empty=%b ovf=%b want 1/1", bus.empty, bus.overflow); end
    endtask

    task automatic test_full_push_pop();
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) push(8'hB0 + 8'(i));
        cyc(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_vec++; if (bus.rd_data !== 8'hB0 || bus.rd_valid !== 1'b1) begin n_bad++; $display("FAIL fpp_pop got %h/%b want b0/1", bus.rd_data, bus.rd_valid); end
        n_vec++; if (bus.count !== 4'd8 || bus.overflow !== 1'b0) begin n_bad++; $display("FAIL fpp_state count=%0d ovf=%b want 8/0", bus.count, bus.overflow); end
        for (int i = 0; i < 8; i++) pop();
        n_vec++; if (bus.rd_data !== 8'h5A || bus.empty !== 1'b1) begin n_bad++; $display("FAIL fpp_last got %h empty=%b want 5a/1", bus.rd_data, bus.empty); end
    endtask

    task automatic test_empty();
        pop();
        n_vec++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 8'h5A || bus.count !== 4'd0) begin n_bad++; $display("FAIL empty_rd got %h/%b cnt=%0d want 5a/0/0", bus.rd_data, bus.rd_valid, bus.count); end
        cyc(1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_vec++; if (bus.count !== 4'd1 || bus.rd_valid !== 1'b0 || bus.empty !== 1'b0) begin n_bad++; $display("FAIL empty_pushpop cnt=%0d vld=%b empty=%b want 1/0/0", bus.count, bus.rd_valid, bus.empty); end
        pop();
        n_vec++; if (bus.rd_data !== 8'h77 || bus.rd_valid !== 1'b1) begin n_bad++; $display("FAIL empty_follow got %h/%b want 77/1", bus.rd_data, bus.rd_valid); end
    endtask

    task automatic test_errors();
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            idle();
        end
        n_vec++; if (bus.parity_err_count !== 8'd2) begin n_bad++; $display("FAIL par_count got %0d want 2", bus.parity_err_count); end
        for (int i = 0; i < 300; i++) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            idle();
        end
        n_vec++; if (bus.stop_err_count !== 8'd255) begin n_bad++; $display("FAIL stop_sat got %0d want 255", bus.stop_err_count); end
        for (int i = 0; i < 9; i++) push(8'hC0);
        n_vec++; if (bus.overflow !== 1'b1) begin n_bad++; $display("FAIL err_ovf_set got %b want 1", bus.overflow); end
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_vec++; if (bus.parity_err_count !== 8'd0 || bus.stop_err_count !== 8'd0 || bus.overflow !== 1'b0) begin n_bad++; $display("FAIL clr got par=%0d stop=%0d ovf=%b want 0", bus.parity_err_count, bus.stop_err_count, bus.overflow); end
        n_vec++; if (bus.count !== 4'd8) begin n_bad++; $display("FAIL clr_keeps_fifo got %0d want 8", bus.count); end
        // Rising edge coinciding with the clear is lost; a held level does not recount
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_vec++; if (bus.parity_err_count !== 8'd0) begin n_bad++; $display("FAIL clr_wins got %0d want 0", bus.parity_err_count); end
        idle();
        for (int i = 0; i < 8; i++) pop();
    endtask

    task automatic test_wrap();
        logic [7:0] d;
        for (int i = 0; i < 20; i++) begin
            d = 8'(i * 13 + 5);
            push(d);
            pop();
            n_vec++; if (bus.rd_data !== d || bus.rd_valid !== 1'b1) begin n_bad++; $display("FAIL wrap%0d got %h/%b want %h/1", i, bus.rd_data, bus.rd_valid, d); end
        end
    endtask

    task automatic test_reset_mid();
        push(8'h01); push(8'h02); push(8'h03);
        cyc(1'b1, 8'h04, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        n_vec++; if (bus.count !== 4'd0 || bus.empty !== 1'b1 || bus.rd_data !== 8'h00 || bus.rd_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid cnt=%0d empty=%b rd=%h/%b want 0/1/00/0", bus.count, bus.empty, bus.rd_data, bus.rd_valid); end
        n_vec++; if (bus.parity_err_count !== 8'd0) begin n_bad++; $display("FAIL rst_mid_par got %0d want 0", bus.parity_err_count); end
        idle();
    endtask

    task automatic test_random();
        logic dv, pe, se, re, clr;
        logic [7:0] d;
        for (int i = 0; i < 600; i++) begin
            dv  = ($urandom_range(0, 99) < 50);
            re  = ($urandom_range(0, 99) < ((i % 200) < 100 ? 25 : 75));
            pe  = ($urandom_range(0, 99) < 30);
            se  = ($urandom_range(0, 99) < 30);
            clr = ($urandom_range(0, 99) < 3);
            d   = 8'($urandom);
            cyc(dv, d, pe, se, re, clr, 1'b0);
            n_vec++;
            if (bus.rd_valid !== m_rd_valid || bus.rd_data !== m_rd_data ||
                bus.count !== 4'(m_q.size()) || bus.empty !== (m_q.size() == 0) ||
                bus.full !== (m_q.size() == DEPTH) || bus.overflow !== m_ovf ||
                bus.parity_err_count !== 8'(m_par) || bus.stop_err_count !== 8'(m_stop)) begin
                n_bad++;
                $display("FAIL rand%0d got rd=%h/%b cnt=%0d e=%b f=%b ovf=%b par=%0d stop=%0d want rd=%h/%b cnt=%0d ovf=%b par=%0d stop=%0d",
                         i, bus.rd_data, bus.rd_valid, bus.count, bus.empty, bus.full, bus.overflow,
                         bus.parity_err_count, bus.stop_err_count, m_rd_data, m_rd_valid, m_q.size(),
                         m_ovf, m_par, m_stop);
            end
        end
    endtask

    initial begin
        bus.data_valid = 1'b0; bus.parallel_data = 8'h00; bus.parity_error = 1'b0;
        bus.stop_error = 1'b0; bus.rd_en = 1'b0; bus.clr_status = 1'b0;
        #2;
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_empty();
        test_errors();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
